// File: rtl/matmul_top.sv
// matmul_top: tiled unsigned matrix multiply C = A*B over internal operand arrays.
// One M_BLOCK x N_BLOCK tile of K_BLOCK-deep dot products issues per cycle; runs once per reset.

module matmul_pe #(
  parameter int DW = 16,
  parameter int KB = 3
) (
  input  logic [KB-1:0][DW-1:0] a,
  input  logic [KB-1:0][DW-1:0] b,
  output logic [2*DW-1:0]       sum
);
  localparam int PW = 2*DW;

  always_comb begin
    sum = '0;
    for (int kk = 0; kk < KB; kk++)
      sum = sum + PW'(a[kk]) * PW'(b[kk]);
  end
endmodule

module matmul_top #(
  parameter int DATA_WIDTH   = 16,
  parameter int M            = 21,
  parameter int K            = 21,
  parameter int N            = 21,
  parameter int M_BLOCK_SIZE = 3,
  parameter int K_BLOCK_SIZE = 3,
  parameter int N_BLOCK_SIZE = 1
) (
  input  logic clk,
  input  logic rst
);
  localparam int PW  = 2*DATA_WIDTH;
  localparam int MT  = M / M_BLOCK_SIZE;
  localparam int NT  = N / N_BLOCK_SIZE;
  localparam int KT  = K / K_BLOCK_SIZE;
  localparam int MTW = (MT > 1) ? $clog2(MT) : 1;
  localparam int NTW = (NT > 1) ? $clog2(NT) : 1;
  localparam int KTW = (KT > 1) ? $clog2(KT) : 1;
  localparam int MW  = (M > 1) ? $clog2(M) : 1;
  localparam int NW  = (N > 1) ? $clog2(N) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;

  // Operands are loaded hierarchically from outside; the block only reads them.
  logic [DATA_WIDTH-1:0] A [0:M-1][0:K-1];
  logic [DATA_WIDTH-1:0] B [0:K-1][0:N-1];
  logic [M*N*PW-1:0]     result;
  logic                  done_pipe;

  typedef enum logic [1:0] {RESET_IDLE, RUN, DRAIN, DONE} state_e;
  state_e state_q, state_d;

  logic [MTW-1:0] mb_q, mb_d, mb1_q, mb1_d;
  logic [NTW-1:0] nb_q, nb_d, nb1_q, nb1_d;
  logic [KTW-1:0] kb_q, kb_d;
  logic           last_mb, last_nb, last_kb, last_tile;
  logic           issue, done_d;
  logic           s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;

  logic [M_BLOCK_SIZE-1:0][K_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] a_tile;
  logic [N_BLOCK_SIZE-1:0][K_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] b_tile;
  logic [M_BLOCK_SIZE-1:0][N_BLOCK_SIZE-1:0][PW-1:0]         pe_sum, psum_q, psum_d;
  logic [M*N*PW-1:0]                                         result_d;

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RESET_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_IDLE: state_d = RUN;
      RUN:        if (last_tile) state_d = DRAIN;
      DRAIN:      if (s1_last_q) state_d = DONE;
      DONE:       state_d = DONE;
      default:    state_d = RESET_IDLE;
    endcase
  end

  // FSM: outputs; done rises with the edge that writes the final tile
  always_comb begin
    issue  = (state_q == RUN);
    done_d = (state_q == DRAIN) && (state_d == DONE);
  end

  assign last_mb   = (mb_q == MTW'(MT-1));
  assign last_nb   = (nb_q == NTW'(NT-1));
  assign last_kb   = (kb_q == KTW'(KT-1));
  assign last_tile = last_mb && last_nb && last_kb;

  // kb innermost, then nb, then mb
  always_comb begin
    mb_d = mb_q;
    nb_d = nb_q;
    kb_d = kb_q;
    if (issue) begin
      if (last_kb) begin
        kb_d = '0;
        if (last_nb) begin
          nb_d = '0;
          mb_d = last_mb ? '0 : mb_q + 1'b1;
        end else begin
          nb_d = nb_q + 1'b1;
        end
      end else begin
        kb_d = kb_q + 1'b1;
      end
    end
  end

  for (genvar gk = 0; gk < K_BLOCK_SIZE; gk++) begin : g_k
    logic [KW-1:0] krow;
    assign krow = KW'(int'(kb_q) * K_BLOCK_SIZE + gk);
    for (genvar gi = 0; gi < M_BLOCK_SIZE; gi++) begin : g_a
      logic [MW-1:0] row;
      assign row            = MW'(int'(mb_q) * M_BLOCK_SIZE + gi);
      assign a_tile[gi][gk] = A[row][krow];
    end
    for (genvar gj = 0; gj < N_BLOCK_SIZE; gj++) begin : g_b
      logic [NW-1:0] col;
      assign col            = NW'(int'(nb_q) * N_BLOCK_SIZE + gj);
      assign b_tile[gj][gk] = B[krow][col];
    end
  end

  for (genvar gi = 0; gi < M_BLOCK_SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < N_BLOCK_SIZE; gj++) begin : g_pe
      matmul_pe #(.DW(DATA_WIDTH), .KB(K_BLOCK_SIZE)) u_pe (
        .a   (a_tile[gi]),
        .b   (b_tile[gj]),
        .sum (pe_sum[gi][gj])
      );
    end
  end

  // Stage 1 captures the tile's partial sums and where they belong
  always_comb begin
    s1_vld_d  = issue;
    s1_last_d = issue && last_tile;
    psum_d    = issue ? pe_sum : psum_q;
    mb1_d     = issue ? mb_q   : mb1_q;
    nb1_d     = issue ? nb_q   : nb1_q;
  end

  // Stage 2: each element compares against the registered tile coordinates
  for (genvar gm = 0; gm < M; gm++) begin : g_rm
    for (genvar gn = 0; gn < N; gn++) begin : g_rn
      logic hit;
      assign hit = s1_vld_q && (mb1_q == MTW'(gm / M_BLOCK_SIZE)) &&
                   (nb1_q == NTW'(gn / N_BLOCK_SIZE));
      assign result_d[(gm*N+gn)*PW +: PW] = hit ?
        result[(gm*N+gn)*PW +: PW] + psum_q[gm % M_BLOCK_SIZE][gn % N_BLOCK_SIZE] :
        result[(gm*N+gn)*PW +: PW];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mb_q      <= '0;
      nb_q      <= '0;
      kb_q      <= '0;
      mb1_q     <= '0;
      nb1_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      psum_q    <= '0;
      result    <= '0;
      done_pipe <= 1'b0;
    end else begin
      mb_q      <= mb_d;
      nb_q      <= nb_d;
      kb_q      <= kb_d;
      mb1_q     <= mb1_d;
      nb1_q     <= nb1_d;
      s1_vld_q  <= s1_vld_d;
      s1_last_q <= s1_last_d;
      psum_q    <= psum_d;
      result    <= result_d;
      done_pipe <= done_d;
    end
  end
endmodule

// File: tb/tb_matmul_top.sv
// Scoreboard bench for matmul_top: five configurations, expectations queued at reset release.
module tb_matmul_top;
  localparam int MAXW = 21*21*32;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {int id; int rel; int lat;} exp_t;
  exp_t sbq[$];

  longint exp_c [0:4][0:20][0:20];
  int    dim_n  [0:4] = '{21, 21, 21, 2, 2};
  int    dim_pw [0:4] = '{32, 32, 32, 32, 8};
  int    lat_of [0:4] = '{1031, 9263, 65, 10, 10};
  string nm_of  [0:4] = '{"def", "b111", "b773", "small", "ovf"};

  matmul_top u_def (.clk(clk), .rst(rst_a));
  matmul_top #(.M_BLOCK_SIZE(1), .K_BLOCK_SIZE(1), .N_BLOCK_SIZE(1)) u_b111 (.clk(clk), .rst(rst_b));
  matmul_top #(.M_BLOCK_SIZE(7), .K_BLOCK_SIZE(7), .N_BLOCK_SIZE(3)) u_b773 (.clk(clk), .rst(rst_b));
  matmul_top #(.M(2), .K(2), .N(2), .M_BLOCK_SIZE(1), .K_BLOCK_SIZE(1), .N_BLOCK_SIZE(1))
    u_small (.clk(clk), .rst(rst_b));
  matmul_top #(.DATA_WIDTH(4), .M(2), .K(2), .N(2), .M_BLOCK_SIZE(1), .K_BLOCK_SIZE(1), .N_BLOCK_SIZE(1))
    u_ovf (.clk(clk), .rst(rst_b));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_mat(input int id, input logic [MAXW-1:0] res);
    longint mask;
    int     n, pw;
    n    = dim_n[id];
    pw   = dim_pw[id];
    mask = (longint'(1) << pw) - 1;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        chk($sformatf("%s.C[%0d][%0d]", nm_of[id], i, j),
            longint'(res >> ((i*n + j)*pw)) & mask, exp_c[id][i][j]);
  endtask

  task automatic on_done(input int id, input logic [MAXW-1:0] res);
    int idx;
    idx = -1;
    for (int i = 0; i < sbq.size(); i++)
      if (idx < 0 && sbq[i].id == id) idx = i;
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL %s.done_unexpected: done_pipe=1 at cycle %0d with no run pending", nm_of[id], cyc);
    end else begin
      chk({nm_of[id], ".latency"}, longint'(cyc - sbq[idx].rel), longint'(sbq[idx].lat));
      check_mat(id, res);
      if (id == 0) begin
        chk("def.C00_const",   longint'(res[31:0]), 60270);
        chk("def.C2020_const", longint'(res[440*32 +: 32]), 2093070);
      end
      sbq.delete(idx);
    end
  endtask

  always @(negedge clk) if (u_def.done_pipe   === 1'b1) on_done(0, MAXW'(u_def.result));
  always @(negedge clk) if (u_b111.done_pipe  === 1'b1) on_done(1, MAXW'(u_b111.result));
  always @(negedge clk) if (u_b773.done_pipe  === 1'b1) on_done(2, MAXW'(u_b773.result));
  always @(negedge clk) if (u_small.done_pipe === 1'b1) on_done(3, MAXW'(u_small.result));
  always @(negedge clk) if (u_ovf.done_pipe   === 1'b1) on_done(4, MAXW'(u_ovf.result));

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < sbq.size(); i++) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: no done_pipe within %0d cycles", nm_of[sbq[i].id], budget);
    end
    sbq.delete();
  endtask

  initial begin
    longint acc;
    int     pulses;
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int i = 0; i < 21; i++)
      for (int j = 0; j < 21; j++) begin
        u_def.A[i][j]  = 16'(i*21 + j);
        u_def.B[i][j]  = 16'(i*21 + j);
        u_b111.A[i][j] = 16'(i*21 + j);
        u_b111.B[i][j] = 16'(i*21 + j);
        u_b773.A[i][j] = 16'(i*21 + j);
        u_b773.B[i][j] = 16'(i*21 + j);
      end
    u_small.A[0][0] = 16'd1; u_small.A[0][1] = 16'd2;
    u_small.A[1][0] = 16'd3; u_small.A[1][1] = 16'd4;
    u_small.B[0][0] = 16'd5; u_small.B[0][1] = 16'd6;
    u_small.B[1][0] = 16'd7; u_small.B[1][1] = 16'd8;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        u_ovf.A[i][j] = 4'hF;
        u_ovf.B[i][j] = 4'hF;
      end

    for (int m = 0; m < 21; m++)
      for (int n = 0; n < 21; n++) begin
        acc = 0;
        for (int k = 0; k < 21; k++)
          acc += longint'(m*21 + k) * longint'(k*21 + n);
        acc &= 64'hFFFF_FFFF;
        for (int id = 0; id < 3; id++) exp_c[id][m][n] = acc;
      end
    exp_c[3][0][0] = 19; exp_c[3][0][1] = 22;
    exp_c[3][1][0] = 43; exp_c[3][1][1] = 50;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) exp_c[4][i][j] = 194;

    repeat (3) @(negedge clk);
    chk("def.rst_result_zero",   longint'(u_def.result == '0), 1);
    chk("def.rst_done_low",      longint'(u_def.done_pipe), 0);
    chk("small.rst_result_zero", longint'(u_small.result == '0), 1);
    chk("ovf.rst_done_low",      longint'(u_ovf.done_pipe), 0);

    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int id = 0; id < 5; id++) sbq.push_back('{id, cyc, lat_of[id]});
    wait_drain(9400);

    pulses = 0;
    repeat (50) begin
      @(negedge clk);
      pulses += int'(u_def.done_pipe) + int'(u_small.done_pipe) + int'(u_b773.done_pipe);
    end
    chk("post_done_pulses", longint'(pulses), 0);
    check_mat(0, MAXW'(u_def.result));
    check_mat(3, MAXW'(u_small.result));

    rst_a = 1'b0;
    #1;
    chk("def.async_clear", longint'(u_def.result == '0), 1);
    repeat (3) @(negedge clk);
    chk("def.hold_done_low", longint'(u_def.done_pipe), 0);

    // released run is aborted below, so no expectation is queued for it
    rst_a = 1'b1;
    repeat (200) @(negedge clk);
    chk("def.midrun_partial", longint'(u_def.result != '0), 1);
    rst_a = 1'b0;
    #1;
    chk("def.midrun_clear", longint'(u_def.result == '0), 1);
    chk("def.midrun_done_low", longint'(u_def.done_pipe), 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    sbq.push_back('{0, cyc, lat_of[0]});
    wait_drain(1200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matmul_top.md
MATMUL_TOP -- requirements
Module: matmul_top

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: bit width of each A and B operand element (unsigned).
REQ-002 The block SHALL have parameters M, K, N, each default 21, defining C[MxN] = A[MxK] * B[KxN].
REQ-003 The block SHALL have parameters M_BLOCK_SIZE, K_BLOCK_SIZE and N_BLOCK_SIZE, defaults 3, 3 and 1, giving the tile size computed per cycle.
REQ-004 The port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state updates on its rising edge.
REQ-005 The port rst SHALL be an input, 1 bit wide: asynchronous, active-low reset (0 = in reset, 1 = run).
REQ-006 The block SHALL have no other ports; operands, results and status SHALL be internal named signals reachable hierarchically, as REQ-007 to REQ-010 define.
REQ-007 A SHALL be an unpacked array reg [DATA_WIDTH-1:0] A[0:M-1][0:K-1]; B SHALL be reg [DATA_WIDTH-1:0] B[0:K-1][0:N-1]; both are loaded by the bench before reset release and are never written by the block.
REQ-008 result SHALL be a flat reg [M*N*2*DATA_WIDTH-1:0]; element C[m][n] SHALL occupy bits [(m*N+n)*2*DATA_WIDTH +: 2*DATA_WIDTH].
REQ-009 done_pipe SHALL be a 1-bit reg that pulses high for exactly one cycle when the final accumulation has been written into result.
REQ-010 M, K and N SHALL be integer multiples of M_BLOCK_SIZE, K_BLOCK_SIZE and N_BLOCK_SIZE respectively; other values are unsupported.

Function
REQ-011 The block SHALL use the FSM states RESET_IDLE, RUN, DRAIN and DONE.
REQ-012 On the first rising edge with rst=1, RESET_IDLE SHALL go to RUN; there is no start input.
REQ-013 In RUN, tile indices (mb, nb, kb) SHALL advance one tile per cycle, kb innermost, then nb, then mb outermost, all starting at 0.
REQ-014 Per RUN cycle, stage 1 SHALL register the M_BLOCK_SIZE x N_BLOCK_SIZE partial sums of the current tile, each the sum over kk<K_BLOCK_SIZE of A[m][k]*B[k][n], with k = kb*K_BLOCK_SIZE+kk.
REQ-015 Stage 2, one cycle after stage 1, SHALL add each registered partial sum into its result element.
REQ-016 Products and sums SHALL be unsigned; all arithmetic SHALL be truncated modulo 2^(2*DATA_WIDTH), with no saturation and no overflow flag.
REQ-017 After the last tile (mb, nb, kb all at maximum) is issued, RUN SHALL go to DRAIN.
REQ-018 DRAIN SHALL last until stage 2 has written the last tile, then go to DONE.
REQ-019 done_pipe SHALL be 1 in the cycle the FSM enters DONE and 0 in every other cycle, including the cycle before it and all cycles after it.
REQ-020 DONE SHALL be terminal: result SHALL hold and no further computation SHALL occur until the next reset.
REQ-021 Total latency from reset release to done_pipe=1 SHALL be (M/M_BLOCK_SIZE)*(N/N_BLOCK_SIZE)*(K/K_BLOCK_SIZE) + 2 cycles.
REQ-022 With the defaults, this latency SHALL be 1031 cycles.
REQ-023 Changing A or B during RUN or DRAIN SHALL have undefined effect on result; the block need not guard against it.

Reset
REQ-024 While rst=0, asynchronously, the FSM SHALL be RESET_IDLE, result SHALL be all zeros, done_pipe SHALL be 0, tile indices SHALL be 0 and the pipeline registers SHALL be cleared.
REQ-025 Reset asserted mid-computation SHALL abort the computation and clear result to 0.
REQ-026 After that reset, release SHALL restart the full computation from tile (0,0,0) using the current contents of A and B.

Verification
REQ-027 Scenario (defaults): A[m][k]=m*21+k, B[k][n]=k*21+n; pulse rst low then high -> done_pipe=1 for one cycle, 1031 cycles after release; C[0][0]=60270 and C[20][20]=2093070; every element matches a reference model.
REQ-028 Scenario: M=K=N=2, all block sizes 1, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> result elements [[19,22],[43,50]]; done_pipe pulses after 10 cycles.
REQ-029 Scenario (overflow): DATA_WIDTH=4, M=K=N=2, block sizes 1, all elements 15 -> every C element equals 450 mod 256 = 194.
REQ-030 Scenario (reset behaviour): hold rst=0 -> result=0 and done_pipe=0; assert rst=0 mid-RUN -> result clears immediately; release -> full latency again and the same correct results.
REQ-031 Scenario (post-done): after done_pipe, run 50 more cycles -> done_pipe stays 0 and result is unchanged.
REQ-032 Scenario (block-shape independence): defaults with block sizes (1,1,1) and (7,7,3) -> results identical to the default run, and latency per REQ-021.
